// File: rtl/enc_pkg.sv
// Shared types and defaults for the rotary encoder front end.
// Holds the quadrature FSM state type and the AB pattern expected in each state.
package enc_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
   localparam int unsigned POS_WIDTH_DEF       = 8;

   typedef enum logic [2:0] {
      IDLE,
      CW1,
      CW2,
      CW3,
      CCW1,
      CCW2,
      CCW3,
      WAIT
   } quad_state_t;

   // AB value that keeps the FSM parked in a given state; WAIT has no home pattern.
   function automatic logic [1:0] state_ab(input quad_state_t s);
      case (s)
         IDLE:    state_ab = 2'b11;
         CW1:     state_ab = 2'b01;
         CW2:     state_ab = 2'b00;
         CW3:     state_ab = 2'b10;
         CCW1:    state_ab = 2'b10;
         CCW2:    state_ab = 2'b00;
         CCW3:    state_ab = 2'b01;
         default: state_ab = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// All stages reset to 1, the idle level of the encoder and button lines.
module enc_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = enc_pkg::DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);

   localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);

   logic        sync1;
   logic        sync2;
   logic [19:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         count  <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any cycle where the input agrees with the output restarts the count.
         if (sync2 == stable) begin
            count <= '0;
         end else if (count == LAST) begin
            stable <= sync2;
            count  <= '0;
         end else begin
            count <= count + 20'd1;
         end
      end
   end

endmodule

// File: rtl/encoder_frontend.sv
// Rotary encoder front end: debounced quadrature decoder, position counter, button events.
// Define ENC_POS_SAT_EN to make position saturate at its signed limits instead of wrapping.
module encoder_frontend
   import enc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned POS_WIDTH       = POS_WIDTH_DEF
) (
   input  logic                 clk50m,
   input  logic                 rst,
   input  logic                 x_clk,
   input  logic                 x_dt,
   input  logic                 x_sw,
   output logic                 step_cw,
   output logic                 step_ccw,
   output logic [POS_WIDTH-1:0] position,
   output logic                 btn_level,
   output logic                 btn_press,
   output logic                 btn_release
);

   logic                 a_db;
   logic                 b_db;
   logic                 sw_db;
   logic                 lvl_q;
   logic [1:0]           ab;
   logic [POS_WIDTH-1:0] pos_inc;
   logic [POS_WIDTH-1:0] pos_dec;
   quad_state_t          state;

   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clk (
      .clk(clk50m), .rst(rst), .raw(x_clk), .stable(a_db)
   );
   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dt (
      .clk(clk50m), .rst(rst), .raw(x_dt), .stable(b_db)
   );
   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
      .clk(clk50m), .rst(rst), .raw(x_sw), .stable(sw_db)
   );

   assign ab        = {a_db, b_db};
   assign btn_level = ~sw_db;

   always_comb begin
`ifdef ENC_POS_SAT_EN
      pos_inc = (position == {1'b0, {(POS_WIDTH-1){1'b1}}}) ? position : position + 1'b1;
      pos_dec = (position == {1'b1, {(POS_WIDTH-1){1'b0}}}) ? position : position - 1'b1;
`else
      pos_inc = position + 1'b1;
      pos_dec = position - 1'b1;
`endif
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state    <= IDLE;
         step_cw  <= 1'b0;
         step_ccw <= 1'b0;
         position <= '0;
      end else begin
         step_cw  <= 1'b0;
         step_ccw <= 1'b0;
         if (state == WAIT) begin
            if (ab == 2'b11) state <= IDLE;
         end else if (ab != state_ab(state)) begin
            if (ab == 2'b11) begin
               // Position moves on the same edge that raises the step pulse.
               state <= IDLE;
               if (state == CW3) begin
                  step_cw  <= 1'b1;
                  position <= pos_inc;
               end else if (state == CCW3) begin
                  step_ccw <= 1'b1;
                  position <= pos_dec;
               end
            end else if ((ab ^ state_ab(state)) == 2'b11) begin
               state <= WAIT;
            end else begin
               // Only single-bit moves reach here: forward step or backtrack.
               case (state)
                  IDLE:    state <= (ab == 2'b01) ? CW1 : CCW1;
                  CW1:     state <= CW2;
                  CW2:     state <= (ab == 2'b10) ? CW3 : CW1;
                  CW3:     state <= CW2;
                  CCW1:    state <= CCW2;
                  CCW2:    state <= (ab == 2'b01) ? CCW3 : CCW1;
                  CCW3:    state <= CCW2;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         lvl_q       <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         lvl_q       <= btn_level;
         btn_press   <= btn_level & ~lvl_q;
         btn_release <= ~btn_level & lvl_q;
      end
   end

endmodule

// File: tb/tb_encoder_frontend.sv
// Directed self-checking bench for encoder_frontend (DEBOUNCE_CYCLES=4, POS_WIDTH=4).
// Honours ENC_POS_SAT_EN when choosing the expected saturation result.
module tb_encoder_frontend;
   import enc_pkg::*;

   logic       clk50m = 1'b0;
   logic       rst;
   logic       x_clk;
   logic       x_dt;
   logic       x_sw;
   logic       step_cw;
   logic       step_ccw;
   logic [3:0] position;
   logic       btn_level;
   logic       btn_press;
   logic       btn_release;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cw_cnt   = 0;
   int unsigned ccw_cnt  = 0;
   int unsigned prs_cnt  = 0;
   int unsigned rel_cnt  = 0;
   int unsigned both_cnt = 0;

   encoder_frontend #(.DEBOUNCE_CYCLES(4), .POS_WIDTH(4)) dut (
      .clk50m(clk50m), .rst(rst), .x_clk(x_clk), .x_dt(x_dt), .x_sw(x_sw),
      .step_cw(step_cw), .step_ccw(step_ccw), .position(position),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   always #10 clk50m = ~clk50m;

   always @(negedge clk50m) begin
      if (step_cw)  cw_cnt  <= cw_cnt + 1;
      if (step_ccw) ccw_cnt <= ccw_cnt + 1;
      if (btn_press)   prs_cnt <= prs_cnt + 1;
      if (btn_release) rel_cnt <= rel_cnt + 1;
      if (step_cw && step_ccw) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk50m);
      #1;
   endtask

   task automatic apply(input logic [1:0] v, input int unsigned n);
      x_clk = v[1];
      x_dt  = v[0];
      cycles(n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2);
   endtask

   task automatic rotate_cw();
      apply(2'b01, 10); apply(2'b00, 10); apply(2'b10, 10); apply(2'b11, 10);
   endtask

   task automatic rotate_ccw();
      apply(2'b10, 10); apply(2'b00, 10); apply(2'b01, 10); apply(2'b11, 10);
   endtask

   initial begin
      int unsigned cw0, ccw0, prs0, rel0;
      rst = 1'b1; x_clk = 1'b1; x_dt = 1'b1; x_sw = 1'b1;
      cycles(3);
      check("rst_position", 32'(position), 32'd0);
      check("rst_step_cw", 32'(step_cw), 32'd0);
      check("rst_step_ccw", 32'(step_ccw), 32'd0);
      check("rst_btn_level", 32'(btn_level), 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      cycles(10);
      check("release_no_pulse", 32'(cw_cnt + ccw_cnt + prs_cnt + rel_cnt), 32'd0);

      // One clockwise detent
      cw0 = cw_cnt; ccw0 = ccw_cnt;
      rotate_cw();
      check("cw_one_pulse", 32'(cw_cnt - cw0), 32'd1);
      check("cw_no_ccw", 32'(ccw_cnt - ccw0), 32'd0);
      check("cw_position", 32'(position), 32'd1);

      // Two counter-clockwise detents from 0
      do_reset();
      check("reset_pos_clear", 32'(position), 32'd0);
      cw0 = cw_cnt; ccw0 = ccw_cnt;
      rotate_ccw();
      rotate_ccw();
      check("ccw_two_pulses", 32'(ccw_cnt - ccw0), 32'd2);
      check("ccw_position", 32'(position), 32'hE);

      // Two-bit jump parks in WAIT until AB returns to 11
      apply(2'b00, 10);
      check("jump_wait", 32'(dut.state), 32'(WAIT));
      apply(2'b10, 10);
      check("wait_hold", 32'(dut.state), 32'(WAIT));
      apply(2'b11, 10);
      check("wait_exit", 32'(dut.state), 32'(IDLE));
      check("wait_no_pulse", 32'(cw_cnt - cw0 + ccw_cnt - ccw0), 32'd2);
      check("wait_position", 32'(position), 32'hE);

      // Glitches on x_clk
      do_reset();
      cw0 = cw_cnt; ccw0 = ccw_cnt;
      x_clk = 1'b0; cycles(3); x_clk = 1'b1;
      cycles(10);
      check("glitch3_state", 32'(dut.state), 32'(IDLE));
      check("glitch3_a_db", 32'(dut.a_db), 32'd1);
      x_clk = 1'b0; cycles(4); x_clk = 1'b1;
      cycles(3);
      check("glitch4_cw1", 32'(dut.state), 32'(CW1));
      cycles(10);
      check("glitch4_idle", 32'(dut.state), 32'(IDLE));
      check("glitch_no_pulse", 32'(cw_cnt - cw0 + ccw_cnt - ccw0), 32'd0);
      check("glitch_position", 32'(position), 32'd0);

      // Eight clockwise detents: wrap or saturate
      do_reset();
      cw0 = cw_cnt;
      for (int i = 0; i < 7; i++) rotate_cw();
      check("cw7_position", 32'(position), 32'd7);
      rotate_cw();
      check("cw8_pulses", 32'(cw_cnt - cw0), 32'd8);
`ifdef ENC_POS_SAT_EN
      check("cw8_position_sat", 32'(position), 32'd7);
`else
      check("cw8_position_wrap", 32'(position), 32'h8);
`endif

      // Button press and release
      prs0 = prs_cnt; rel0 = rel_cnt;
      x_sw = 1'b0;
      cycles(6);
      check("btn_level_at6", 32'(btn_level), 32'd1);
      check("btn_press_at6", 32'(btn_press), 32'd0);
      cycles(1);
      check("btn_press_at7", 32'(btn_press), 32'd1);
      cycles(13);
      x_sw = 1'b1;
      cycles(12);
      check("btn_press_count", 32'(prs_cnt - prs0), 32'd1);
      check("btn_release_count", 32'(rel_cnt - rel0), 32'd1);
      check("btn_level_released", 32'(btn_level), 32'd0);

      // Reset mid-rotation at CW2
      do_reset();
      cw0 = cw_cnt;
      apply(2'b11, 10); apply(2'b01, 10); apply(2'b00, 10);
      check("mid_cw2", 32'(dut.state), 32'(CW2));
      rst = 1'b1;
      cycles(3);
      check("mid_rst_position", 32'(position), 32'd0);
      check("mid_rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      apply(2'b00, 10); apply(2'b10, 10); apply(2'b11, 10);
      check("mid_no_step", 32'(cw_cnt - cw0), 32'd0);
      check("mid_final_state", 32'(dut.state), 32'(IDLE));
      check("mid_final_pos", 32'(position), 32'd0);

      check("never_both_steps", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
